// File: rtl/branch_resolve_unit_if.sv
// Bus bundle for branch_resolve_unit: fetch push side, EX resolve side and
// the registered predictor feedback / flush / counter outputs.
interface branch_resolve_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  CACHE_READY;
  logic                  CACHE_READY_DATA;
  logic                  FETCH_VALID;
  logic [ADDR_WIDTH-1:0] FETCH_PC;
  logic [ADDR_WIDTH-1:0] FETCH_PRD_ADDR;
  logic                  FETCH_READY;
  logic                  EX_VALID;
  logic [ADDR_WIDTH-1:0] EX_PC_IN;
  logic                  EX_IS_BRANCH;
  logic                  EX_TAKEN;
  logic [ADDR_WIDTH-1:0] EX_TARGET;
  logic                  EX_IS_RETURN;
  logic                  BRANCH;
  logic                  BRANCH_TAKEN;
  logic [ADDR_WIDTH-1:0] BRANCH_ADDR;
  logic                  RETURN;
  logic                  PREDICTED;
  logic [ADDR_WIDTH-1:0] EX_PC;
  logic                  FLUSH;
  logic [ADDR_WIDTH-1:0] REDIRECT_ADDR;
  logic [31:0]           BRANCH_COUNT;
  logic [31:0]           MISPRED_COUNT;
  logic                  ERR;

  modport master (
    output CACHE_READY, CACHE_READY_DATA, FETCH_VALID, FETCH_PC, FETCH_PRD_ADDR,
           EX_VALID, EX_PC_IN, EX_IS_BRANCH, EX_TAKEN, EX_TARGET, EX_IS_RETURN,
    input  FETCH_READY, BRANCH, BRANCH_TAKEN, BRANCH_ADDR, RETURN, PREDICTED,
           EX_PC, FLUSH, REDIRECT_ADDR, BRANCH_COUNT, MISPRED_COUNT, ERR
  );

  modport slave (
    input  CACHE_READY, CACHE_READY_DATA, FETCH_VALID, FETCH_PC, FETCH_PRD_ADDR,
           EX_VALID, EX_PC_IN, EX_IS_BRANCH, EX_TAKEN, EX_TARGET, EX_IS_RETURN,
    output FETCH_READY, BRANCH, BRANCH_TAKEN, BRANCH_ADDR, RETURN, PREDICTED,
           EX_PC, FLUSH, REDIRECT_ADDR, BRANCH_COUNT, MISPRED_COUNT, ERR
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: queues fetch predictions, checks them at EX,
// and returns registered predictor feedback plus flush/redirect and counters.
module branch_resolve_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4
) (
  input logic                 CLK,
  input logic                 RST,
  branch_resolve_unit_if.slave bus
);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] r_q_pc  [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] r_q_prd [QUEUE_DEPTH];
  logic [PTR_W-1:0]      r_rd, r_wr;
  logic [CNT_W-1:0]      r_count;

  logic                  r_branch, r_taken, r_return, r_predicted, r_flush, r_err;
  logic [ADDR_WIDTH-1:0] r_branch_addr, r_ex_pc, r_redirect;
  logic [31:0]           r_branch_cnt, r_mispred_cnt;

  logic                  w_adv, w_ready, w_push, w_pop, w_correct, w_empty_ex;
  logic [ADDR_WIDTH-1:0] w_actual_next;

  always_comb begin
    w_adv         = bus.CACHE_READY & bus.CACHE_READY_DATA;
    w_ready       = (r_count != CNT_W'(QUEUE_DEPTH));
    w_push        = w_adv & bus.FETCH_VALID & w_ready & ~r_flush;
    w_pop         = w_adv & bus.EX_VALID & (r_count != '0);
    w_empty_ex    = w_adv & bus.EX_VALID & (r_count == '0);
    w_actual_next = (bus.EX_IS_BRANCH & bus.EX_TAKEN) ? bus.EX_TARGET
                                                       : bus.EX_PC_IN + ADDR_WIDTH'(4);
    w_correct     = (r_q_pc[r_rd] == bus.EX_PC_IN) & (r_q_prd[r_rd] == w_actual_next);
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_q_pc[r_wr]  <= bus.FETCH_PC;
      r_q_prd[r_wr] <= bus.FETCH_PRD_ADDR;
    end
  end

  // A mispredicted pop clears the whole queue; any same-edge push is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (w_pop && !w_correct) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)  r_rd <= r_rd + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_branch      <= 1'b0;
      r_taken       <= 1'b0;
      r_branch_addr <= '0;
      r_return      <= 1'b0;
      r_predicted   <= 1'b1;
      r_ex_pc       <= '0;
      r_flush       <= 1'b0;
      r_redirect    <= '0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
      r_err         <= 1'b0;
    end else if (!w_adv) begin
      r_flush <= 1'b0;
    end else if (w_pop) begin
      r_branch      <= bus.EX_IS_BRANCH;
      r_taken       <= bus.EX_TAKEN & bus.EX_IS_BRANCH;
      r_branch_addr <= bus.EX_TARGET;
      r_return      <= bus.EX_IS_RETURN;
      r_ex_pc       <= bus.EX_PC_IN;
      r_predicted   <= w_correct;
      r_flush       <= ~w_correct;
      if (!w_correct) begin
        r_redirect    <= w_actual_next;
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
      if (bus.EX_IS_BRANCH) r_branch_cnt <= r_branch_cnt + 32'd1;
    end else begin
      r_branch    <= 1'b0;
      r_predicted <= 1'b1;
      r_flush     <= 1'b0;
      if (w_empty_ex) r_err <= 1'b1;
    end
  end

  always_comb begin
    bus.FETCH_READY   = w_ready;
    bus.BRANCH        = r_branch;
    bus.BRANCH_TAKEN  = r_taken;
    bus.BRANCH_ADDR   = r_branch_addr;
    bus.RETURN        = r_return;
    bus.PREDICTED     = r_predicted;
    bus.EX_PC         = r_ex_pc;
    bus.FLUSH         = r_flush;
    bus.REDIRECT_ADDR = r_redirect;
    bus.BRANCH_COUNT  = r_branch_cnt;
    bus.MISPRED_COUNT = r_mispred_cnt;
    bus.ERR           = r_err;
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  branch_resolve_unit_if #(.ADDR_WIDTH(32)) bus ();

  branch_resolve_unit #(.ADDR_WIDTH(32), .QUEUE_DEPTH(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic v, input logic [31:0] pc, input logic [31:0] prd);
    bus.FETCH_VALID    = v;
    bus.FETCH_PC       = pc;
    bus.FETCH_PRD_ADDR = prd;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic br,
                        input logic tk, input logic [31:0] tgt, input logic ret);
    bus.EX_VALID     = v;
    bus.EX_PC_IN     = pc;
    bus.EX_IS_BRANCH = br;
    bus.EX_TAKEN     = tk;
    bus.EX_TARGET    = tgt;
    bus.EX_IS_RETURN = ret;
  endtask

  initial begin
    int push_i;
    int pop_i;
    rst = 1'b1;
    bus.CACHE_READY      = 1'b1;
    bus.CACHE_READY_DATA = 1'b1;
    set_fetch(1'b0, '0, '0);
    set_ex(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    #2;
    chk("rst_fetch_ready", bus.FETCH_READY, 1);
    chk("rst_predicted",   bus.PREDICTED, 1);
    chk("rst_branch",      bus.BRANCH, 0);
    chk("rst_flush",       bus.FLUSH, 0);
    chk("rst_bcnt",        bus.BRANCH_COUNT, 0);
    chk("rst_err",         bus.ERR, 0);
    #10 rst = 1'b0;

    // sequential non-branch stream
    for (int i = 0; i < 3; i++) begin
      set_fetch(1'b1, 32'h100 + 32'(4*i), 32'h104 + 32'(4*i));
      cycle();
    end
    set_fetch(1'b0, '0, '0);
    chk("seq_count3", dut.r_count, 3);
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 32'h100 + 32'(4*i), 1'b0, 1'b0, '0, 1'b0);
      cycle();
      chk("seq_pred",  bus.PREDICTED, 1);
      chk("seq_flush", bus.FLUSH, 0);
      chk("seq_expc",  bus.EX_PC, 32'h100 + 32'(4*i));
      chk("seq_br",    bus.BRANCH, 0);
    end
    set_ex(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("seq_bcnt",  bus.BRANCH_COUNT, 0);
    chk("seq_empty", dut.r_count, 0);

    // taken branch, correctly predicted
    set_fetch(1'b1, 32'h200, 32'h400);
    cycle();
    set_fetch(1'b0, '0, '0);
    set_ex(1'b1, 32'h200, 1'b1, 1'b1, 32'h400, 1'b0);
    cycle();
    chk("tk_branch", bus.BRANCH, 1);
    chk("tk_taken",  bus.BRANCH_TAKEN, 1);
    chk("tk_addr",   bus.BRANCH_ADDR, 32'h400);
    chk("tk_pred",   bus.PREDICTED, 1);
    chk("tk_flush",  bus.FLUSH, 0);
    chk("tk_bcnt",   bus.BRANCH_COUNT, 1);
    chk("tk_mcnt",   bus.MISPRED_COUNT, 0);
    set_ex(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    cycle();
    chk("idle_branch",   bus.BRANCH, 0);
    chk("idle_addrhold", bus.BRANCH_ADDR, 32'h400);

    // mispredict clears queue; same-edge push dropped
    for (int i = 0; i < 3; i++) begin
      set_fetch(1'b1, 32'h300 + 32'(4*i), 32'h304 + 32'(4*i));
      cycle();
    end
    set_fetch(1'b1, 32'h30C, 32'h310);
    set_ex(1'b1, 32'h300, 1'b1, 1'b1, 32'h500, 1'b0);
    cycle();
    chk("mp_flush", bus.FLUSH, 1);
    chk("mp_redir", bus.REDIRECT_ADDR, 32'h500);
    chk("mp_pred",  bus.PREDICTED, 0);
    chk("mp_mcnt",  bus.MISPRED_COUNT, 1);
    chk("mp_bcnt",  bus.BRANCH_COUNT, 2);
    chk("mp_count", dut.r_count, 0);
    set_fetch(1'b0, '0, '0);
    set_ex(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    cycle();
    chk("mp_flush_1cyc", bus.FLUSH, 0);
    chk("mp_pred_back",  bus.PREDICTED, 1);

    // fill, then stream across pointer wrap
    for (int i = 0; i < 4; i++) begin
      set_fetch(1'b1, 32'h1000 + 32'(4*i), 32'h1004 + 32'(4*i));
      cycle();
    end
    chk("full_ready", bus.FETCH_READY, 0);
    set_fetch(1'b1, 32'h1010, 32'h1014);
    set_ex(1'b1, 32'h1000, 1'b0, 1'b0, '0, 1'b0);
    cycle();
    chk("full_pop_ready", bus.FETCH_READY, 1);
    chk("full_pop_pred",  bus.PREDICTED, 1);
    chk("full_nopush",    dut.r_count, 3);
    push_i = 4;
    pop_i  = 1;
    for (int i = 0; i < 10; i++) begin
      set_fetch(1'b1, 32'h1000 + 32'(4*push_i), 32'h1004 + 32'(4*push_i));
      set_ex(1'b1, 32'h1000 + 32'(4*pop_i), 1'b0, 1'b0, '0, 1'b0);
      cycle();
      chk("wrap_pred", bus.PREDICTED, 1);
      chk("wrap_expc", bus.EX_PC, 32'h1000 + 32'(4*pop_i));
      push_i++;
      pop_i++;
    end
    set_fetch(1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 32'h1000 + 32'(4*pop_i), 1'b0, 1'b0, '0, 1'b0);
      cycle();
      chk("drain_pred", bus.PREDICTED, 1);
      chk("drain_expc", bus.EX_PC, 32'h1000 + 32'(4*pop_i));
      pop_i++;
    end
    set_ex(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("drain_empty", dut.r_count, 0);
    chk("wrap_mcnt",   bus.MISPRED_COUNT, 1);

    // stall holds everything
    set_fetch(1'b1, 32'h600, 32'h604);
    cycle();
    bus.CACHE_READY_DATA = 1'b0;
    set_fetch(1'b1, 32'h700, 32'h704);
    set_ex(1'b1, 32'h600, 1'b1, 1'b0, 32'h777, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_expc",  bus.EX_PC, 32'h1034);
      chk("stall_br",    bus.BRANCH, 0);
      chk("stall_flush", bus.FLUSH, 0);
      chk("stall_count", dut.r_count, 1);
    end
    bus.CACHE_READY_DATA = 1'b1;
    set_fetch(1'b0, '0, '0);
    cycle();
    chk("rel_br",    bus.BRANCH, 1);
    chk("rel_taken", bus.BRANCH_TAKEN, 0);
    chk("rel_ret",   bus.RETURN, 1);
    chk("rel_expc",  bus.EX_PC, 32'h600);
    chk("rel_pred",  bus.PREDICTED, 1);
    chk("rel_bcnt",  bus.BRANCH_COUNT, 3);
    chk("rel_empty", dut.r_count, 0);
    set_ex(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

    // flush followed by stall: FLUSH drops, other outputs hold
    set_fetch(1'b1, 32'h800, 32'h900);
    cycle();
    set_fetch(1'b0, '0, '0);
    set_ex(1'b1, 32'h800, 1'b0, 1'b0, '0, 1'b0);
    cycle();
    chk("mp2_flush", bus.FLUSH, 1);
    chk("mp2_redir", bus.REDIRECT_ADDR, 32'h804);
    chk("mp2_mcnt",  bus.MISPRED_COUNT, 2);
    set_ex(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    bus.CACHE_READY = 1'b0;
    cycle();
    chk("fst_flush", bus.FLUSH, 0);
    chk("fst_pred",  bus.PREDICTED, 0);
    chk("fst_redir", bus.REDIRECT_ADDR, 32'h804);
    bus.CACHE_READY = 1'b1;
    cycle();
    chk("fst_pred_back", bus.PREDICTED, 1);

    // PC+4 wraps at 2^32
    set_fetch(1'b1, 32'hFFFF_FFFC, 32'h0);
    cycle();
    set_fetch(1'b0, '0, '0);
    set_ex(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, '0, 1'b0);
    cycle();
    chk("pcwrap_pred",  bus.PREDICTED, 1);
    chk("pcwrap_flush", bus.FLUSH, 0);
    chk("pre_err",      bus.ERR, 0);

    // EX_VALID on empty queue
    set_ex(1'b1, 32'h999, 1'b1, 1'b1, 32'h123, 1'b0);
    cycle();
    chk("err_set",  bus.ERR, 1);
    chk("err_br",   bus.BRANCH, 0);
    chk("err_pred", bus.PREDICTED, 1);
    chk("err_bcnt", bus.BRANCH_COUNT, 3);
    chk("err_mcnt", bus.MISPRED_COUNT, 2);
    set_ex(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    set_fetch(1'b1, 32'hA00, 32'hA04);
    cycle();
    set_fetch(1'b0, '0, '0);
    chk("err_sticky", bus.ERR, 1);

    // asynchronous reset between edges, during a stall
    bus.CACHE_READY = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_err",   bus.ERR, 0);
    chk("arst_bcnt",  bus.BRANCH_COUNT, 0);
    chk("arst_mcnt",  bus.MISPRED_COUNT, 0);
    chk("arst_expc",  bus.EX_PC, 0);
    chk("arst_redir", bus.REDIRECT_ADDR, 0);
    chk("arst_addr",  bus.BRANCH_ADDR, 0);
    chk("arst_pred",  bus.PREDICTED, 1);
    chk("arst_ready", bus.FETCH_READY, 1);
    chk("arst_count", dut.r_count, 0);
    #2 rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-side counterpart of the fetch-side branch predictor.
- Tracks every fetch-stage prediction (PC, predicted next PC) in a small in-flight queue until the instruction resolves in EX.
- Compares the predicted next PC against the actual outcome and produces the registered resolution/update feedback (BRANCH, BRANCH_TAKEN, BRANCH_ADDR, RETURN, PREDICTED, FLUSH, EX_PC) consumed by the predictor.
- Also drives the pipeline flush/redirect and keeps performance counters.

Parameters:
- ADDR_WIDTH, 32, PC/target width.
- QUEUE_DEPTH, 4, in-flight prediction entries (power of 2, ≥2).

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- CACHE_READY  in  1  instruction cache ready; the unit advances only when CACHE_READY & CACHE_READY_DATA (called "adv")
- CACHE_READY_DATA  in  1  data cache ready
- FETCH_VALID  in  1  fetch issued an instruction this cycle
- FETCH_PC  in  ADDR_WIDTH  PC of the fetched instruction
- FETCH_PRD_ADDR  in  ADDR_WIDTH  next PC chosen by the predictor for that instruction
- FETCH_READY  out  1  queue not full
- EX_VALID  in  1  instruction resolving in EX this cycle
- EX_PC_IN  in  ADDR_WIDTH  PC of the resolving instruction
- EX_IS_BRANCH  in  1  instruction is a control transfer
- EX_TAKEN  in  1  control transfer taken
- EX_TARGET  in  ADDR_WIDTH  resolved target
- EX_IS_RETURN  in  1  instruction is a return
- BRANCH  out  1  registered: a control transfer resolved
- BRANCH_TAKEN  out  1  registered outcome
- BRANCH_ADDR  out  ADDR_WIDTH  registered resolved target
- RETURN  out  1  registered return flag
- PREDICTED  out  1  registered: prediction was correct
- EX_PC  out  ADDR_WIDTH  registered PC of the resolved instruction
- FLUSH  out  1  one-cycle pipeline flush
- REDIRECT_ADDR  out  ADDR_WIDTH  correct next PC, valid with FLUSH
- BRANCH_COUNT  out  32  resolved control transfers
- MISPRED_COUNT  out  32  mispredictions
- ERR  out  1  sticky: EX_VALID seen while queue empty

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset values:
  - All outputs 0, except PREDICTED=1 and FETCH_READY=1.
  - Queue empty, counters 0, ERR 0.
- Queue: circular buffer with read/write pointers and an occupancy count 0..QUEUE_DEPTH.
  - FETCH_READY = (count != QUEUE_DEPTH), combinational.
  - Push on adv & FETCH_VALID & FETCH_READY & !FLUSH.
  - Pop on adv & EX_VALID & count != 0.
  - Pointers wrap modulo QUEUE_DEPTH.
  - Simultaneous push and pop leaves count unchanged. With count==QUEUE_DEPTH, a pop frees a slot but no same-cycle push occurs, because FETCH_READY was low.
- Resolution, computed combinationally on pop:
  - actual_next = (EX_IS_BRANCH & EX_TAKEN) ? EX_TARGET : EX_PC_IN + 4, modulo 2^ADDR_WIDTH.
  - correct = (head.pc == EX_PC_IN) & (head.prd == actual_next).
- Outputs, registered one cycle after the pop (latency 1):
  - BRANCH = EX_IS_BRANCH
  - BRANCH_TAKEN = EX_TAKEN & EX_IS_BRANCH
  - BRANCH_ADDR = EX_TARGET
  - RETURN = EX_IS_RETURN
  - EX_PC = EX_PC_IN
  - PREDICTED = correct
- Misprediction (!correct):
  - FLUSH=1 for exactly one cycle; REDIRECT_ADDR = actual_next.
  - Queue cleared: pointers and count to 0 in the same edge as the pop; pushes that cycle are discarded.
  - MISPRED_COUNT increments.
- BRANCH_COUNT increments on every pop with EX_IS_BRANCH.
- Counters wrap at 2^32.
- Cycle after a flush: FLUSH=0, and EX_VALID arriving for wrong-path instructions finds the queue empty (see next item).
- EX_VALID with empty queue:
  - No pop; ERR set (sticky until reset).
  - BRANCH=0, PREDICTED=1 and FLUSH=0 registered.
- Stall (!adv):
  - All registered outputs hold, except FLUSH, which clears to 0.
  - Queue and counters hold.
  - EX inputs are ignored.
- Cycle with no pop and adv: BRANCH=0, FLUSH=0, PREDICTED=1; other outputs hold.
- Reset mid-operation: immediate clear to reset values regardless of CLK or stall.

Test Plan:
- Sequential stream: push PCs 0x100, 0x104, 0x108 with prd = pc+4; EX resolves each as non-branch → PREDICTED=1 each cycle, FLUSH never, BRANCH_COUNT=0, queue empty at end.
- Taken branch, correct prediction: push pc 0x200, prd 0x400; EX_PC_IN 0x200, taken, target 0x400 → next cycle BRANCH=1, BRANCH_TAKEN=1, BRANCH_ADDR=0x400, PREDICTED=1, FLUSH=0, BRANCH_COUNT=1.
- Mispredict with clear: push 0x300 (prd 0x304), 0x304, 0x308; EX resolves 0x300 taken to 0x500 → FLUSH=1 for one cycle, REDIRECT_ADDR=0x500, PREDICTED=0, MISPRED_COUNT=1, count=0, and a push on that edge is dropped.
- Full/wrap: push 4 entries → FETCH_READY=0; pop one → FETCH_READY=1; push/pop 10 more → order preserved across pointer wrap, all PREDICTED=1.
- Stall: hold CACHE_READY_DATA=0 for 3 cycles with EX_VALID=1 and FETCH_VALID=1 → no pops or pushes, outputs hold, FLUSH=0; release → single resolution processed.
- Error/reset: EX_VALID with empty queue → ERR=1, counters unchanged; assert RST asynchronously between edges → all outputs to reset values immediately, ERR=0.
